// File: rtl/rtype_pkg.sv
// rtype_pkg: shared FSM encoding, funct/opcode constants and instruction field positions
package rtype_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_READ, S_EXEC, S_WRITE} state_e;
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
endpackage

// File: rtl/rtype_alu.sv
// rtype_alu: combinational R-type ALU
// Ports: funct/shamt select the operation on a (rs) and b (rt); result, signed
// overflow (ADD/SUB only) and supported (funct is implemented) come back.
module rtype_alu
  import rtype_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [5:0]            funct,
  input  logic [4:0]            shamt,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  supported
);
  localparam int M = DATA_WIDTH - 1;
  logic [DATA_WIDTH-1:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;
  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    supported = 1'b1;
    case (funct)
      FUNCT_ADD: begin
        result   = sum;
        overflow = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      FUNCT_SUB: begin
        result   = diff;
        overflow = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      FUNCT_AND: result = a & b;
      FUNCT_OR:  result = a | b;
      FUNCT_XOR: result = a ^ b;
      FUNCT_NOR: result = ~(a | b);
      FUNCT_SLT: result = {{M{1'b0}}, $signed(a) < $signed(b)};
      FUNCT_SLL: result = b << shamt;
      FUNCT_SRL: result = b >> shamt;
      default:   supported = 1'b0;
    endcase
  end
endmodule

// File: rtl/rtype_exec_sequencer.sv
// rtype_exec_sequencer: executes one R-type instruction as READ/EXEC/WRITE on a single-port-op register file
// Ports: clock/reset (async, active low); instr/instr_valid/instr_ready handshake and
// clear_req upstream; rf_* controls and rf_data_1/2 to/from the register file;
// done/illegal/overflow status pulses.
module rtype_exec_sequencer
  import rtype_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic                      clear_req,
  output logic [DATA_WIDTH-1:0]     rf_in,
  output logic [REG_ADDR_WIDTH-1:0] rf_select_input,
  output logic [REG_ADDR_WIDTH-1:0] rf_select_output_1,
  output logic [REG_ADDR_WIDTH-1:0] rf_select_output_2,
  output logic                      rf_read,
  output logic                      rf_write,
  output logic                      rf_enable,
  output logic                      rf_reset,
  input  logic [DATA_WIDTH-1:0]     rf_data_1,
  input  logic [DATA_WIDTH-1:0]     rf_data_2,
  output logic                      done,
  output logic                      illegal,
  output logic                      overflow
);
  state_e                state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d, alu_result;
  logic                  ovf_q, ovf_d, alu_ovf, alu_ok, legal;
  rtype_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .funct    (instr_q[FUNCT_LSB +: 6]),
    .shamt    (instr_q[SHAMT_LSB +: 5]),
    .a        (rf_data_1),
    .b        (rf_data_2),
    .result   (alu_result),
    .overflow (alu_ovf),
    .supported(alu_ok)
  );
  assign legal = (instr_q[OPCODE_LSB +: 6] == OPCODE_RTYPE) && alu_ok;
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        state_d = clear_req ? S_CLEAR : instr_valid ? S_READ : S_IDLE;
        instr_d = (!clear_req && instr_valid) ? instr : instr_q;
      end
      S_READ: state_d = legal ? S_EXEC : S_IDLE;
      S_EXEC: begin
        state_d  = S_WRITE;
        result_d = alu_result;
        ovf_d    = alu_ovf;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end
  // Selects come straight from the latch, so they hold their value between instructions.
  assign rf_select_output_1 = instr_q[RS_LSB +: REG_ADDR_WIDTH];
  assign rf_select_output_2 = instr_q[RT_LSB +: REG_ADDR_WIDTH];
  assign rf_select_input    = instr_q[RD_LSB +: REG_ADDR_WIDTH];
  assign rf_in              = result_q;
  // Ready stays low while reset is held and rises on release.
  assign instr_ready = reset && (state_q == S_IDLE);
  assign rf_enable   = (state_q == S_CLEAR) || (state_q == S_READ) || (state_q == S_WRITE);
  assign rf_reset    = (state_q == S_CLEAR);
  assign rf_read     = (state_q == S_READ);
  // r0 is hard-wired zero: its write strobe is suppressed but done still retires.
  assign rf_write    = (state_q == S_WRITE) && (rf_select_input != '0);
  assign done        = (state_q == S_WRITE);
  assign overflow    = (state_q == S_WRITE) && ovf_q;
  assign illegal     = (state_q == S_READ) && !legal;
endmodule
